// File: rtl/serial_port_transmitter_if.sv
// Bundle of the serial router's step enable, serial input and routed outputs.
// The state field mirrors the FSM register so checkers can bind to it.
interface serial_port_transmitter_if;
    logic       clkEn;
    logic       SerIn;
    logic       SerOutValid;
    logic       Done;
    logic       P0;
    logic       P1;
    logic       P2;
    logic       P3;
    logic [6:0] SSD_Out;
    logic [2:0] state;

    // Handshake: there is no ready; on each rising clk with clkEn=1 the router consumes
    // exactly one SerIn bit, and SerOutValid=1 marks that the same bit appears on P[port].
    modport master (
        output clkEn, SerIn,
        input  SerOutValid, Done, P0, P1, P2, P3, SSD_Out, state
    );

    modport slave (
        input  clkEn, SerIn,
        output SerOutValid, Done, P0, P1, P2, P3, SSD_Out, state
    );
endinterface

// File: rtl/serial_port_transmitter.sv
// Serial-to-port router: start bit, 2-bit port id, 4-bit length, then N data bits
// forwarded to one of four outputs, with a seven-segment countdown of remaining bits.
module serial_port_transmitter (
    input  logic                      clk,
    input  logic                      rst,
    serial_port_transmitter_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PORT = 3'd1,
        LEN  = 3'd2,
        XMIT = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] port_q, port_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] bc_q, bc_d;
    logic [3:0] len_shift;
    logic       xmit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            port_q  <= 2'd0;
            cnt_q   <= 4'd0;
            bc_q    <= 3'd0;
        end else if (bus.clkEn) begin
            state_q <= state_d;
            port_q  <= port_d;
            cnt_q   <= cnt_d;
            bc_q    <= bc_d;
        end
    end

    // Length as it will look once the current bit is shifted in; decides XMIT vs DONE.
    assign len_shift = {cnt_q[2:0], bus.SerIn};

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        cnt_d   = cnt_q;
        bc_d    = bc_q;
        case (state_q)
            IDLE: begin
                if (!bus.SerIn) begin
                    state_d = PORT;
                    bc_d    = 3'd0;
                end
            end
            PORT: begin
                port_d = {port_q[0], bus.SerIn};
                if (bc_q == 3'd1) begin
                    state_d = LEN;
                    bc_d    = 3'd0;
                end else begin
                    bc_d = bc_q + 3'd1;
                end
            end
            LEN: begin
                cnt_d = len_shift;
                if (bc_q == 3'd3) begin
                    state_d = (len_shift != 4'd0) ? XMIT : DONE;
                    bc_d    = 3'd0;
                end else begin
                    bc_d = bc_q + 3'd1;
                end
            end
            XMIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign xmit            = (state_q == XMIT);
    assign bus.SerOutValid = xmit;
    assign bus.Done        = (state_q == DONE);
    assign bus.P0          = bus.SerIn & xmit & (port_q == 2'd0);
    assign bus.P1          = bus.SerIn & xmit & (port_q == 2'd1);
    assign bus.P2          = bus.SerIn & xmit & (port_q == 2'd2);
    assign bus.P3          = bus.SerIn & xmit & (port_q == 2'd3);
    assign bus.state       = state_q;

    // Active-low segments ordered {g,f,e,d,c,b,a}.
    always_comb begin
        bus.SSD_Out = 7'b1000000;
        case (cnt_q)
            4'h0: bus.SSD_Out = 7'b1000000;
            4'h1: bus.SSD_Out = 7'b1111001;
            4'h2: bus.SSD_Out = 7'b0100100;
            4'h3: bus.SSD_Out = 7'b0110000;
            4'h4: bus.SSD_Out = 7'b0011001;
            4'h5: bus.SSD_Out = 7'b0010010;
            4'h6: bus.SSD_Out = 7'b0000010;
            4'h7: bus.SSD_Out = 7'b1111000;
            4'h8: bus.SSD_Out = 7'b0000000;
            4'h9: bus.SSD_Out = 7'b0010000;
            4'hA: bus.SSD_Out = 7'b0001000;
            4'hB: bus.SSD_Out = 7'b0000011;
            4'hC: bus.SSD_Out = 7'b1000110;
            4'hD: bus.SSD_Out = 7'b0100001;
            4'hE: bus.SSD_Out = 7'b0000110;
            4'hF: bus.SSD_Out = 7'b0001110;
            default: bus.SSD_Out = 7'b1000000;
        endcase
    end
endmodule

// File: tb/tb_serial_port_transmitter.sv
// Bench for the serial router: a directed vector table, hand-written corner sequences
// and random frames checked against a frame-level model of the expected step outputs.
module tb_serial_port_transmitter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    serial_port_transmitter_if bus ();

    serial_port_transmitter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ser;
        logic       en;
        logic       rst;
        logic       v;
        logic       d;
        logic [3:0] p;
        logic [6:0] ssd;
    } vec_t;

    vec_t tbl[17];

    function automatic logic [6:0] seg(input int n);
        logic [6:0] s;
        case (n)
            0:  s = 7'b1000000;  1:  s = 7'b1111001;  2:  s = 7'b0100100;  3:  s = 7'b0110000;
            4:  s = 7'b0011001;  5:  s = 7'b0010010;  6:  s = 7'b0000010;  7:  s = 7'b1111000;
            8:  s = 7'b0000000;  9:  s = 7'b0010000;  10: s = 7'b0001000;  11: s = 7'b0000011;
            12: s = 7'b1000110;  13: s = 7'b0100001;  14: s = 7'b0000110;  default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // One clock step: drive inputs on the falling edge, compare 1 ns later.
    task automatic step(input logic ser, input logic en, input logic r, input logic v,
                        input logic d, input logic [3:0] p, input logic [6:0] ssd,
                        input string name);
        logic [12:0] act, exp_v;
        @(negedge clk);
        bus.SerIn = ser;
        bus.clkEn = en;
        rst       = r;
        #1;
        act   = {bus.SerOutValid, bus.Done, bus.P3, bus.P2, bus.P1, bus.P0, bus.SSD_Out};
        exp_v = {v, d, p, ssd};
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s t=%0t got valid/done/p/ssd=%b/%b/%b/%b want %b/%b/%b/%b",
                     name, $time, act[12], act[11], act[10:7], act[6:0],
                     v, d, p, ssd);
        end
    endtask

    task automatic idle_steps(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0, seg(0), "idle");
    endtask

    // Frame-level model: bit i of the frame and the outputs visible while it is presented.
    task automatic run_frame(input logic [1:0] port, input logic [3:0] len,
                             input logic [15:0] data, input int stall_at, input int stall_cnt,
                             input int stall_pct, input int abort_at, input string tag);
        int         nlen;
        logic       ser, v, d;
        logic [3:0] p;
        logic [6:0] ssd;
        int         nst;
        logic [3:0] lv;
        nlen = int'(len);
        lv   = len;
        for (int i = 0; i <= 7 + nlen; i++) begin
            v = 1'b0; d = 1'b0; p = 4'b0; ssd = seg(0);
            if (i == 0) begin
                ser = 1'b0;
            end else if (i < 3) begin
                ser = port[2 - i];
            end else if (i < 7) begin
                ser = lv[6 - i];
                ssd = seg(nlen >> (7 - i));
            end else if (i < 7 + nlen) begin
                ser = data[i - 7];
                v   = 1'b1;
                p   = ser ? (4'b0001 << port) : 4'b0000;
                ssd = seg(nlen - (i - 7));
            end else begin
                ser = 1'($urandom_range(1));
                d   = 1'b1;
            end
            nst = (i == stall_at) ? stall_cnt
                  : ((int'($urandom_range(99)) < stall_pct) ? int'($urandom_range(1, 3)) : 0);
            for (int k = 0; k < nst; k++) step(ser, 1'b0, 1'b0, v, d, p, ssd, {tag, "_stall"});
            if (i == abort_at) begin
                step(ser, 1'b0, 1'b1, v, d, p, ssd, {tag, "_abort_step"});
                step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0, seg(0), {tag, "_after_rst"});
                return;
            end
            step(ser, 1'b1, 1'b0, v, d, p, ssd, tag);
        end
    endtask

    initial begin
        bus.SerIn = 1'b1;
        bus.clkEn = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);

        // Reset values, and SerIn=1 keeps the router idle.
        for (int k = 0; k < 3; k++)
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0, seg(0), "reset_idle");

        // Port 3, length 8, data 1,1,0,0,1,1,0,1.
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, seg(0)};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, seg(0)};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, seg(0)};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, seg(0)};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, seg(1)};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, seg(2)};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, seg(4)};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, seg(8)};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, seg(7)};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, seg(6)};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, seg(5)};
        tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, seg(4)};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, seg(3)};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, seg(2)};
        tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, seg(1)};
        tbl[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, seg(0)};
        tbl[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, seg(0)};
        for (int k = 0; k < 17; k++)
            step(tbl[k].ser, tbl[k].en, tbl[k].rst, tbl[k].v, tbl[k].d, tbl[k].p, tbl[k].ssd,
                 $sformatf("table_%0d", k));

        run_frame(2'd1, 4'd3, 16'b101, -1, 0, 0, -1, "port1_len3");
        run_frame(2'd0, 4'd0, 16'h0, -1, 0, 0, -1, "len0_back_to_back");
        idle_steps(2);
        run_frame(2'd2, 4'd9, 16'h01B5, 10, 5, 0, -1, "freeze_mid_xmit");
        run_frame(2'd3, 4'd15, 16'h6D5B, -1, 0, 0, -1, "len15");
        run_frame(2'd1, 4'd6, 16'h002D, -1, 0, 0, 9, "abort_xmit");
        idle_steps(2);
        run_frame(2'd0, 4'd4, 16'h000D, -1, 0, 0, -1, "fresh_after_abort");

        for (int f = 0; f < 40; f++) begin
            idle_steps(int'($urandom_range(0, 2)));
            run_frame(2'($urandom_range(3)), 4'($urandom_range(15)), 16'($urandom),
                      -1, 0, 25, -1, $sformatf("rand_%0d", f));
        end
        idle_steps(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
